tmp75_i2c_target: RTL and testbench

TMP75_I2C_TARGET -- requirements
Module: tmp75_i2c_target

---
 rtl/tmp75_i2c_target.sv | 229 ++++++++++++++++++++++
 tb/tb_tmp75_i2c_target.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmp75_i2c_target.sv
// TMP75-style I2C target: pointer, temperature, config, TLOW and THIGH registers.
// Optional comparator alert output is enabled by defining TMP75_ALERT_EN.
module tmp75_i2c_target #(
  parameter logic [3:0]  DEV_ADDR_HI = 4'b1001,
  parameter logic [15:0] TLOW_RST    = 16'h4B00,
  parameter logic [15:0] THIGH_RST   = 16'h5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  addr,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  input  logic [15:0] temp_in,
  output logic        busy,
  output logic        reg_wr,
  output logic        alert_n
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK} state_t;

  state_t      state, state_n;
  logic        scl_meta, scl_sync, scl_prev, sda_meta, sda_sync, sda_prev;
  logic        sda_q, sda_n;
  logic [3:0]  bit_cnt, cnt_n;
  logic [7:0]  shift, shift_n;
  logic [1:0]  wr_phase, phase_n;
  logic [1:0]  pointer, ptr_n;
  logic [7:0]  hold_msb, hold_n;
  logic [15:0] cfg, cfg_n, tlow, tlow_n, thigh, thigh_n, shadow, shadow_n;
  logic        rd_lsb, lsb_n, wr_q, wr_n;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [15:0] reg_val;
  logic [7:0]  rd_byte;
  logic [2:0]  bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta <= 1'b1; scl_sync <= 1'b1; scl_prev <= 1'b1;
      sda_meta <= 1'b1; sda_sync <= 1'b1; sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl_i; scl_sync <= scl_meta; scl_prev <= scl_sync;
      sda_meta <= sda_i; sda_sync <= sda_meta; sda_prev <= sda_sync;
    end
  end

  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

  always_comb begin
    case (pointer)
      2'd0:    reg_val = temp_in;
      2'd1:    reg_val = cfg;
      2'd2:    reg_val = tlow;
      default: reg_val = thigh;
    endcase
  end

  assign rd_byte = rd_lsb ? shadow[7:0] : shadow[15:8];
  assign bit_idx = 3'd7 - bit_cnt[2:0];

  // STOP and START override every state; otherwise act only on synchronized SCL edges.
  always_comb begin
    state_n  = state;
    sda_n    = sda_q;
    cnt_n    = bit_cnt;
    shift_n  = shift;
    phase_n  = wr_phase;
    ptr_n    = pointer;
    hold_n   = hold_msb;
    cfg_n    = cfg;
    tlow_n   = tlow;
    thigh_n  = thigh;
    shadow_n = shadow;
    lsb_n    = rd_lsb;
    wr_n     = 1'b0;
    if (stop_det) begin
      state_n = IDLE;
      sda_n   = 1'b1;
    end else if (start_det) begin
      state_n = ADDR;
      cnt_n   = 4'd0;
      sda_n   = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shift_n = {shift[6:0], sda_sync};
            cnt_n   = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shift[7:1] == {DEV_ADDR_HI, addr}) begin
              state_n = ADDR_ACK;
              sda_n   = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (shift[0]) begin
              state_n  = RD_BYTE;
              shadow_n = reg_val;
              lsb_n    = 1'b0;
              sda_n    = reg_val[15];
              cnt_n    = 4'd1;
            end else begin
              state_n = WR_BYTE;
              sda_n   = 1'b1;
              phase_n = 2'd0;
              cnt_n   = 4'd0;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shift_n = {shift[6:0], sda_sync};
            cnt_n   = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_n = WR_ACK;
            sda_n   = 1'b0;
            case (wr_phase)
              2'd0: begin ptr_n = shift[1:0]; phase_n = 2'd1; end
              2'd1: begin hold_n = shift; phase_n = 2'd2; end
              default: begin
                phase_n = 2'd1;
                if (pointer != 2'd0) wr_n = 1'b1;
                case (pointer)
                  2'd1:    cfg_n   = {hold_msb, shift};
                  2'd2:    tlow_n  = {hold_msb, shift};
                  2'd3:    thigh_n = {hold_msb, shift};
                  default: ;
                endcase
              end
            endcase
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_n = WR_BYTE;
            sda_n   = 1'b1;
            cnt_n   = 4'd0;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n = RD_ACK;
              sda_n   = 1'b1;
            end else begin
              sda_n = rd_byte[bit_idx];
              cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_sync) begin
            state_n = IDLE;
          end else if (scl_fall) begin
            state_n = RD_BYTE;
            lsb_n   = ~rd_lsb;
            sda_n   = rd_lsb ? shadow[15] : shadow[7];
            cnt_n   = 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sda_q    <= 1'b1;
      bit_cnt  <= 4'd0;
      shift    <= 8'd0;
      wr_phase <= 2'd0;
      pointer  <= 2'd0;
      hold_msb <= 8'd0;
      cfg      <= 16'h00FF;
      tlow     <= TLOW_RST;
      thigh    <= THIGH_RST;
      shadow   <= 16'd0;
      rd_lsb   <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state    <= state_n;
      sda_q    <= sda_n;
      bit_cnt  <= cnt_n;
      shift    <= shift_n;
      wr_phase <= phase_n;
      pointer  <= ptr_n;
      hold_msb <= hold_n;
      cfg      <= cfg_n;
      tlow     <= tlow_n;
      thigh    <= thigh_n;
      shadow   <= shadow_n;
      rd_lsb   <= lsb_n;
      wr_q     <= wr_n;
    end
  end

  assign sda_o  = sda_q;
  assign reg_wr = wr_q;
  assign busy   = !(state == IDLE || state == ADDR);

`ifdef TMP75_ALERT_EN
  logic alert_q;

  // Comparator with hysteresis: set at or above THIGH, clear below TLOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert_q <= 1'b1;
    end else if ($signed(temp_in[15:4]) >= $signed(thigh[15:4])) begin
      alert_q <= 1'b0;
    end else if ($signed(temp_in[15:4]) < $signed(tlow[15:4])) begin
      alert_q <= 1'b1;
    end
  end

  assign alert_n = alert_q;
`else
  assign alert_n = 1'b1;
`endif

endmodule

// File: tb/tb_tmp75_i2c_target.sv
// Table-driven bench for tmp75_i2c_target using a bit-banged I2C master model.
// Alert checks follow the TMP75_ALERT_EN build setting.
module tb_tmp75_i2c_target;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [2:0]  addr = 3'b000;
  logic [15:0] temp_in = 16'h0000;
  logic        sda_o, busy, reg_wr, alert_n;
  logic        sda_bus;

  int n_vec = 0;
  int n_bad = 0;
  int wr_pulses = 0;

  typedef struct {
    bit        do_wr;
    bit [1:0]  ptr;
    bit [15:0] wdata;
    bit [15:0] temp;
    bit [15:0] exp;
    int        exp_wr;
  } vec_t;

  vec_t vecs[9];

  assign sda_bus = sda_m & sda_o;

  tmp75_i2c_target dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .scl_i   (scl_m),
    .sda_i   (sda_bus),
    .sda_o   (sda_o),
    .temp_in (temp_in),
    .busy    (busy),
    .reg_wr  (reg_wr),
    .alert_n (alert_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reg_wr) wr_pulses++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    end
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_clk(T);
    scl_m = 1'b1; wait_clk(T);
    sda_m = 1'b0; wait_clk(T);
    scl_m = 1'b0; wait_clk(T);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_clk(T);
    scl_m = 1'b1; wait_clk(T);
    sda_m = 1'b1; wait_clk(T);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clk(T);
    scl_m = 1'b1; wait_clk(T);
    scl_m = 1'b0; wait_clk(2);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_clk(T);
    scl_m = 1'b1; wait_clk(T / 2);
    b = sda_bus;  wait_clk(T / 2);
    scl_m = 1'b0; wait_clk(2);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack);
  endtask

  task automatic read_reg_pair(input logic [1:0] ptr, output logic [15:0] val, output logic [2:0] acks);
    logic [7:0] msb, lsb;
    i2c_start;
    write_byte(8'h90, acks[0]);
    write_byte({6'd0, ptr}, acks[1]);
    i2c_start;
    write_byte(8'h91, acks[2]);
    read_byte(msb, 1'b0);
    read_byte(lsb, 1'b1);
    i2c_stop;
    val = {msb, lsb};
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    logic [3:0]  wacks;
    logic [2:0]  racks;
    logic [15:0] val;
    int          base;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    temp_in = v.temp;
    base = wr_pulses;
    if (v.do_wr) begin
      i2c_start;
      write_byte(8'h90, wacks[0]);
      write_byte({6'd0, v.ptr}, wacks[1]);
      write_byte(v.wdata[15:8], wacks[2]);
      write_byte(v.wdata[7:0], wacks[3]);
      check_output({tag, "_busy_wr"}, 16'(busy), 16'd1);
      i2c_stop;
      check_output({tag, "_wr_acks"}, 16'(wacks), 16'h0);
    end
    check_output({tag, "_reg_wr_count"}, 16'(wr_pulses - base), 16'(v.exp_wr));
    read_reg_pair(v.ptr, val, racks);
    check_output({tag, "_rd_acks"}, 16'(racks), 16'h0);
    check_output({tag, "_rd_data"}, val, v.exp);
    check_output({tag, "_busy_idle"}, 16'(busy), 16'd0);
  endtask

  initial begin : main
    logic        ack, ack2;
    logic [7:0]  b0, b1, b2;
    logic [15:0] val;
    logic [2:0]  racks;
    int          base;

    vecs[0] = '{1'b0, 2'd0, 16'h0000, 16'h1900, 16'h1900, 0};
    vecs[1] = '{1'b0, 2'd1, 16'h0000, 16'h1900, 16'h00FF, 0};
    vecs[2] = '{1'b0, 2'd2, 16'h0000, 16'h1900, 16'h4B00, 0};
    vecs[3] = '{1'b0, 2'd3, 16'h0000, 16'h1900, 16'h5000, 0};
    vecs[4] = '{1'b1, 2'd3, 16'h5500, 16'h1900, 16'h5500, 1};
    vecs[5] = '{1'b1, 2'd2, 16'h1230, 16'h1900, 16'h1230, 1};
    vecs[6] = '{1'b1, 2'd0, 16'hABCD, 16'hE700, 16'hE700, 0};
    vecs[7] = '{1'b1, 2'd1, 16'h0060, 16'hE700, 16'h0060, 1};
    vecs[8] = '{1'b0, 2'd0, 16'h0000, 16'h7FF0, 16'h7FF0, 0};

    // Values held during reset
    wait_clk(3);
    check_output("rst_sda_o", 16'(sda_o), 16'd1);
    check_output("rst_busy", 16'(busy), 16'd0);
    check_output("rst_reg_wr", 16'(reg_wr), 16'd0);
    check_output("rst_alert_n", 16'(alert_n), 16'd1);
    rst_n = 1'b1;
    wait_clk(5);

    // Address for another device is not acknowledged
    i2c_start;
    write_byte(8'h92, ack);
    check_output("wrong_addr_ack", 16'(ack), 16'd1);
    check_output("wrong_addr_busy", 16'(busy), 16'd0);
    i2c_stop;
    check_output("wrong_addr_busy_end", 16'(busy), 16'd0);

    // Write stopped after the MSB leaves TLOW alone
    base = wr_pulses;
    i2c_start;
    write_byte(8'h90, ack);
    write_byte(8'h02, ack2);
    write_byte(8'h12, b0[0]);
    i2c_stop;
    check_output("partial_wr_acks", 16'({ack, ack2, b0[0]}), 16'h0);
    check_output("partial_wr_pulses", 16'(wr_pulses - base), 16'd0);

    // Config read through a stored pointer, three bytes with wrap
    i2c_start;
    write_byte(8'h90, ack);
    write_byte(8'h01, ack2);
    i2c_stop;
    i2c_start;
    write_byte(8'h91, ack);
    check_output("cfg_rd_addr_ack", 16'(ack), 16'd0);
    read_byte(b0, 1'b0);
    read_byte(b1, 1'b0);
    read_byte(b2, 1'b1);
    i2c_stop;
    check_output("cfg_rd_bytes", 16'({b0, b1}), 16'h00FF);
    check_output("cfg_rd_wrap", 16'(b2), 16'h0000);

    // Temperature snapshot is immune to changes mid-read
    i2c_start;
    write_byte(8'h90, ack);
    write_byte(8'h00, ack2);
    i2c_stop;
    temp_in = 16'h1910;
    i2c_start;
    write_byte(8'h91, ack);
    read_byte(b0, 1'b0);
    temp_in = 16'h2AB0;
    read_byte(b1, 1'b1);
    i2c_stop;
    check_output("temp_snapshot", {b0, b1}, 16'h1910);

    for (int i = 0; i < 9; i++) apply_stimulus(vecs[i], i);

    // Reset asserted while the target drives a zero data bit
    temp_in = 16'h0000;
    i2c_start;
    write_byte(8'h90, ack);
    write_byte(8'h00, ack2);
    i2c_stop;
    i2c_start;
    write_byte(8'h91, ack);
    wait_clk(4);
    check_output("mid_read_sda_low", 16'(sda_o), 16'd0);
    check_output("mid_read_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    check_output("mid_read_rst_sda", 16'(sda_o), 16'd1);
    check_output("mid_read_rst_busy", 16'(busy), 16'd0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    i2c_stop;
    read_reg_pair(2'd3, val, racks);
    check_output("post_rst_thigh", val, 16'h5000);
    check_output("post_rst_acks", 16'(racks), 16'h0);

`ifdef TMP75_ALERT_EN
    temp_in = 16'h5000; wait_clk(5);
    check_output("alert_at_thigh", 16'(alert_n), 16'd0);
    temp_in = 16'h4C00; wait_clk(5);
    check_output("alert_hold", 16'(alert_n), 16'd0);
    temp_in = 16'h4A00; wait_clk(5);
    check_output("alert_below_tlow", 16'(alert_n), 16'd1);
`else
    temp_in = 16'h5000; wait_clk(5);
    check_output("alert_disabled_hi", 16'(alert_n), 16'd1);
    temp_in = 16'h7FF0; wait_clk(5);
    check_output("alert_disabled_max", 16'(alert_n), 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
